id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage directly upstream of alu. It captures decoded fields and register-file data from the decode stage and selects immediate/shamt operands. It resolves EX/MEM and MEM/WB forwarding and drives the alu inputs a, b and aluc. It also detects load-use hazards, signalling a stall to PC/IF/ID and inserting a bubble into EX.

---
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand select feeding the alu.
// Captures decoded fields, resolves EX/MEM and MEM/WB forwarding,
// and detects load-use hazards (stall upstream, bubble into EX).
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_wa,
    input  logic [15:0]   id_imm16,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_aluc,
    input  logic          id_alusrc,
    input  logic          id_sext,
    input  logic          id_shift,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          flush,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_wa,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_wa,
    input  logic [DW-1:0] wb_result,
    output logic          stall,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_aluc,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wa,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite
);

    logic          valid;
    logic [RW-1:0] rs, rt, wa;
    logic [DW-1:0] rs_data, rt_data;
    logic [15:0]   imm;
    logic [4:0]    shamt;
    logic [3:0]    aluc;
    logic          alusrc, sext, shift;
    logic          regwrite, memread, memwrite;

    logic          hazard;
    logic [DW-1:0] fwd_rs, fwd_rt, imm_ext;

    // Load-use detection against the instruction waiting in ID
    always_comb begin
        hazard = valid && memread && (wa != '0) && id_valid &&
                 ((wa == id_rs) || ((wa == id_rt) && (!id_alusrc || id_memwrite)));
        stall  = hazard && !flush;
    end

    // EX register: flush or hazard loads a fully cleared bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;  rs      <= '0;    rt       <= '0;   wa       <= '0;
            rs_data  <= '0;    rt_data <= '0;    imm      <= '0;   shamt    <= '0;
            aluc     <= '0;    alusrc  <= 1'b0;  sext     <= 1'b0; shift    <= 1'b0;
            regwrite <= 1'b0;  memread <= 1'b0;  memwrite <= 1'b0;
        end else if (flush || hazard) begin
            valid    <= 1'b0;  rs      <= '0;    rt       <= '0;   wa       <= '0;
            rs_data  <= '0;    rt_data <= '0;    imm      <= '0;   shamt    <= '0;
            aluc     <= '0;    alusrc  <= 1'b0;  sext     <= 1'b0; shift    <= 1'b0;
            regwrite <= 1'b0;  memread <= 1'b0;  memwrite <= 1'b0;
        end else begin
            valid    <= id_valid;    rs      <= id_rs;      rt       <= id_rt;
            wa       <= id_wa;       rs_data <= id_rs_data; rt_data  <= id_rt_data;
            imm      <= id_imm16;    shamt   <= id_shamt;   aluc     <= id_aluc;
            alusrc   <= id_alusrc;   sext    <= id_sext;    shift    <= id_shift;
            regwrite <= id_regwrite; memread <= id_memread; memwrite <= id_memwrite;
        end
    end

    // Forwarding (EX/MEM over MEM/WB, never for $0) and operand select
    always_comb begin
        fwd_rs = rs_data;
        if (mem_regwrite && (mem_wa != '0) && (mem_wa == rs))
            fwd_rs = mem_result;
        else if (wb_regwrite && (wb_wa != '0) && (wb_wa == rs))
            fwd_rs = wb_result;

        fwd_rt = rt_data;
        if (mem_regwrite && (mem_wa != '0) && (mem_wa == rt))
            fwd_rt = mem_result;
        else if (wb_regwrite && (wb_wa != '0) && (wb_wa == rt))
            fwd_rt = wb_result;

        imm_ext = sext ? {{(DW-16){imm[15]}}, imm} : {{(DW-16){1'b0}}, imm};

        alu_a         = shift  ? {{(DW-5){1'b0}}, shamt} : fwd_rs;
        alu_b         = alusrc ? imm_ext : fwd_rt;
        alu_aluc      = aluc;
        ex_store_data = fwd_rt;
        ex_wa         = wa;
        ex_regwrite   = regwrite && valid;
        ex_memread    = memread  && valid;
        ex_memwrite   = memwrite && valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_alusrc, id_sext, id_shift;
    logic        id_regwrite, id_memread, id_memwrite, flush;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] id_rs_data, id_rt_data, mem_result, wb_result;
    logic [4:0]  id_rs, id_rt, id_wa, id_shamt, mem_wa, wb_wa;
    logic [15:0] id_imm16;
    logic [3:0]  id_aluc;

    logic        stall, ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_aluc;
    logic [4:0]  ex_wa;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa),
        .id_imm16(id_imm16), .id_shamt(id_shamt), .id_aluc(id_aluc),
        .id_alusrc(id_alusrc), .id_sext(id_sext), .id_shift(id_shift),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_wa(mem_wa), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_wa(wb_wa), .wb_result(wb_result),
        .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .ex_store_data(ex_store_data), .ex_wa(ex_wa),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    // Instruction occupying EX, as the model sees it
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, wa, shamt;
        bit [31:0] rs_data, rt_data;
        bit [15:0] imm;
        bit [3:0]  aluc;
        bit        alusrc, sext, shift, regwrite, memread, memwrite;
    } instr_t;

    typedef struct {
        string     tag;
        bit        stall;
        bit [31:0] a, b, sd;
        bit [3:0]  aluc;
        bit [4:0]  wa;
        bit        rw, mr, mw;
    } exp_t;

    instr_t ex_m;
    exp_t   sb[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     done = 1'b0;

    function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] captured);
        if (r != 0 && mem_regwrite && mem_wa == r) return mem_result;
        if (r != 0 && wb_regwrite && wb_wa == r)   return wb_result;
        return captured;
    endfunction

    function automatic bit load_use();
        if (!(ex_m.valid && ex_m.memread && ex_m.wa != 0 && id_valid)) return 1'b0;
        if (ex_m.wa == id_rs) return 1'b1;
        return (ex_m.wa == id_rt) && (!id_alusrc || id_memwrite);
    endfunction

    task automatic idle();
        rst = 0; flush = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0;
        id_rs = 0; id_rt = 0; id_wa = 0; id_imm16 = 0; id_shamt = 0; id_aluc = 0;
        id_alusrc = 0; id_sext = 0; id_shift = 0; id_regwrite = 0;
        id_memread = 0; id_memwrite = 0;
        mem_regwrite = 0; mem_wa = 0; mem_result = 0;
        wb_regwrite = 0; wb_wa = 0; wb_result = 0;
    endtask

    // Inputs are already driven; predict this cycle, then advance one edge
    task automatic step(input string tag);
        exp_t   e;
        instr_t nx;
        bit     hz;
        if (rst) ex_m = '{default: 0};
        #1;
        hz      = load_use();
        e.tag   = tag;
        e.stall = hz && !flush;
        e.a     = ex_m.shift ? 32'(ex_m.shamt) : operand(ex_m.rs, ex_m.rs_data);
        e.sd    = operand(ex_m.rt, ex_m.rt_data);
        e.b     = !ex_m.alusrc ? e.sd :
                  ex_m.sext ? 32'($signed(ex_m.imm)) : 32'(ex_m.imm);
        e.aluc  = ex_m.aluc;
        e.wa    = ex_m.wa;
        e.rw    = ex_m.valid && ex_m.regwrite;
        e.mr    = ex_m.valid && ex_m.memread;
        e.mw    = ex_m.valid && ex_m.memwrite;
        sb.push_back(e);
        if (rst || flush || hz) nx = '{default: 0};
        else nx = '{valid: id_valid, rs: id_rs, rt: id_rt, wa: id_wa, shamt: id_shamt,
                    rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm16, aluc: id_aluc,
                    alusrc: id_alusrc, sext: id_sext, shift: id_shift,
                    regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};
        @(posedge clk);
        ex_m = nx;
        #1;
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 3) != 0);
        id_rs_data = $urandom; id_rt_data = $urandom;
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_wa = 5'($urandom_range(0, 3));
        id_imm16 = 16'($urandom); id_shamt = 5'($urandom); id_aluc = 4'($urandom);
        id_alusrc = 1'($urandom); id_sext = 1'($urandom); id_shift = ($urandom_range(0, 3) == 0);
        id_regwrite = 1'($urandom); id_memread = ($urandom_range(0, 2) == 0);
        id_memwrite = ($urandom_range(0, 3) == 0);
    endtask

    // Monitor: outputs are combinational, so every negedge presents a result
    always @(negedge clk) begin
        if (!done && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (stall !== e.stall || alu_a !== e.a || alu_b !== e.b || alu_aluc !== e.aluc ||
                ex_store_data !== e.sd || ex_wa !== e.wa || ex_regwrite !== e.rw ||
                ex_memread !== e.mr || ex_memwrite !== e.mw) begin
                miscompares++;
                $display("FAIL %s: got stall=%0b a=%h b=%h aluc=%h sd=%h wa=%0d rw/mr/mw=%b%b%b, want stall=%0b a=%h b=%h aluc=%h sd=%h wa=%0d rw/mr/mw=%b%b%b",
                         e.tag, stall, alu_a, alu_b, alu_aluc, ex_store_data, ex_wa,
                         ex_regwrite, ex_memread, ex_memwrite, e.stall, e.a, e.b, e.aluc,
                         e.sd, e.wa, e.rw, e.mr, e.mw);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ex_m = '{default: 0};
        idle();
        // Reset with random decode inputs
        rst = 1; rand_id();
        @(posedge clk); #1;
        step("reset"); rand_id(); step("reset_rand");
        idle(); id_valid = 1; id_aluc = 4'b0010; id_regwrite = 1; id_wa = 5'd4;
        step("release"); idle(); step("first_capture");

        // Immediate extension and shamt
        id_valid = 1; id_alusrc = 1; id_sext = 1; id_imm16 = 16'h8000; step("imm_cap");
        id_sext = 0; step("imm_sext");
        id_alusrc = 0; id_shift = 1; id_shamt = 5'd31; step("imm_zext");
        idle(); step("shamt31");

        // Forward priority
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h0BAD_0BAD; step("fwd_cap");
        mem_regwrite = 1; mem_wa = 3; mem_result = 32'hAAAA0000;
        wb_regwrite = 1; wb_wa = 3; wb_result = 32'h5555; step("fwd_mem");
        mem_regwrite = 0; step("fwd_wb");
        id_rs = 0; id_rs_data = 32'h1234; step("fwd_r0_cap");
        mem_regwrite = 1; mem_wa = 0; wb_wa = 0; step("fwd_r0");

        // Load-use: one stall cycle then capture of the held instruction
        idle(); id_valid = 1; id_memread = 1; id_regwrite = 1; id_wa = 5'd8; step("lw_cap");
        idle(); id_valid = 1; id_rs = 5'd8; id_aluc = 4'h6; id_regwrite = 1; id_wa = 5'd9;
        step("lu_stall");
        step("lu_bubble");
        step("lu_captured");

        // Flush against hazard, then flush alone
        idle(); id_valid = 1; id_memread = 1; id_regwrite = 1; id_wa = 5'd8; step("lw2_cap");
        idle(); id_valid = 1; id_rt = 5'd8; flush = 1; step("flush_hz");
        flush = 0; id_aluc = 4'h7; id_regwrite = 1; id_memwrite = 1; step("after_flush");
        flush = 1; step("flush_only");
        idle(); step("flushed");

        // Store forwarding with immediate offset
        id_valid = 1; id_alusrc = 1; id_sext = 1; id_imm16 = 16'hFFFC; id_rt = 5'd9;
        id_rs = 5'd2; id_memwrite = 1; id_rt_data = 32'hDEAD; step("sw_cap");
        idle(); mem_regwrite = 1; mem_wa = 9; mem_result = 32'h12345678; step("sw_fwd");

        // Randomized traffic with frequent register collisions
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rst = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            mem_regwrite = 1'($urandom); mem_wa = 5'($urandom_range(0, 3)); mem_result = $urandom;
            wb_regwrite = 1'($urandom); wb_wa = 5'($urandom_range(0, 3)); wb_result = $urandom;
            step("random");
        end

        @(negedge clk); #1;
        done = 1'b1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
